// File: rtl/spi_reg_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_bridge_pkg
// Description : Shared state encoding and command constants for the SPI
//               register bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_reg_bridge_pkg;

  // Bridge decoder states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_FETCH = 3'd1,
    ST_RD_LOAD  = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_WR_DATA  = 3'd4
  } state_t;

  // Command byte bit selecting read (1) or write (0)
  localparam int CMD_RD_BIT = 7;

  // Byte presented to the master while it clocks in the command byte
  localparam logic [7:0] DEF_STATUS_BYTE = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/spi_cs_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_cs_sync
// Description : Two-flop synchronizer for the raw SPI chip select plus
//               single-cycle rise/fall pulses. Resets to "CS high" so a
//               select held low across reset shows up as a fresh fall.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_cs_sync (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_CS_n,
  output logic o_Rise,
  output logic o_Fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Metastability filter followed by one delay stage for edge detection
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= i_CS_n;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign o_Rise = sync_q & ~prev_q;
  assign o_Fall = ~sync_q & prev_q;

endmodule
`default_nettype wire

// File: rtl/spi_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_bridge
// Description : Decodes the SPI slave RX byte stream into register bank
//               read/write strobes and returns read data through the slave
//               TX byte. Frames are delimited by the synchronized chip select.
//               Optional feature macro SPI_BRIDGE_AUTOINC_EN: when defined the
//               address steps by one per data/dummy byte (burst access); when
//               undefined the address is fixed for the frame (FIFO port use).
// Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_bridge
  import spi_reg_bridge_pkg::*;
#(
  parameter int          ADDR_W      = 7,
  parameter logic [7:0]  STATUS_BYTE = DEF_STATUS_BYTE
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic              i_SPI_CS_n,
  input  logic              i_RX_DV,
  input  logic [7:0]        i_RX_Byte,
  output logic              o_TX_DV,
  output logic [7:0]        o_TX_Byte,
  output logic [ADDR_W-1:0] o_Reg_Addr,
  output logic              o_Reg_WE,
  output logic [7:0]        o_Reg_WData,
  output logic              o_Reg_RE,
  input  logic [7:0]        i_Reg_RData,
  output logic              o_Busy
);

`ifdef SPI_BRIDGE_AUTOINC_EN
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(1);
`else
  localparam logic [ADDR_W-1:0] ADDR_STEP = '0;
`endif

  logic              cs_rise;
  logic              cs_fall;
  logic              rx_ok;

  state_t            state_q,   state_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic              busy_q,    busy_d;
  logic              tx_dv_q,   tx_dv_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              we_q,      we_d;
  logic [7:0]        wdata_q,   wdata_d;

  spi_cs_sync u_cs_sync (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_CS_n  (i_SPI_CS_n),
    .o_Rise  (cs_rise),
    .o_Fall  (cs_fall)
  );

  // Bytes arriving outside a frame are dropped
  assign rx_ok = i_RX_DV & busy_q;

  // State and output registers; TX_DV comes out of reset set to preload status
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      tx_dv_q   <= 1'b1;
      tx_byte_q <= STATUS_BYTE;
      we_q      <= 1'b0;
      wdata_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
    end
  end

  // Next-state decode; frame end overrides everything except a byte already in flight
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    busy_d    = busy_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    we_d      = 1'b0;
    wdata_d   = wdata_q;

    // Write address advances the cycle after its strobe so the strobe sees the old address
    if (we_q) begin
      addr_d = addr_q + ADDR_STEP;
    end

    case (state_q)
      ST_IDLE: begin
        if (rx_ok) begin
          addr_d  = i_RX_Byte[ADDR_W-1:0];
          state_d = i_RX_Byte[CMD_RD_BIT] ? ST_RD_FETCH : ST_WR_DATA;
        end
      end
      ST_RD_FETCH: begin
        state_d = ST_RD_LOAD;
      end
      ST_RD_LOAD: begin
        tx_dv_d   = 1'b1;
        tx_byte_d = i_Reg_RData;
        state_d   = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (rx_ok) begin
          addr_d  = addr_q + ADDR_STEP;
          state_d = ST_RD_FETCH;
        end
      end
      ST_WR_DATA: begin
        if (rx_ok) begin
          we_d    = 1'b1;
          wdata_d = i_RX_Byte;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (cs_rise) begin
      state_d   = ST_IDLE;
      busy_d    = 1'b0;
      tx_dv_d   = 1'b1;
      tx_byte_d = STATUS_BYTE;
    end else if (cs_fall) begin
      state_d = ST_IDLE;
      busy_d  = 1'b1;
    end
  end

  assign o_TX_DV     = tx_dv_q;
  assign o_TX_Byte   = tx_byte_q;
  assign o_Reg_Addr  = addr_q;
  assign o_Reg_WE    = we_q;
  assign o_Reg_WData = wdata_q;
  assign o_Reg_RE    = (state_q == ST_RD_FETCH);
  assign o_Busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_reg_bridge
// Description : Self-checking bench for spi_reg_bridge: byte-level frame
//               stimulus, register bank model, event scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_reg_bridge;

  localparam logic [7:0] STATUS = 8'hA5;
`ifdef SPI_BRIDGE_AUTOINC_EN
  localparam logic [6:0] STEP = 7'd1;
`else
  localparam logic [6:0] STEP = 7'd0;
`endif
  localparam int GAP = 20;

  localparam logic [1:0] EV_WE = 2'd0;
  localparam logic [1:0] EV_RE = 2'd1;
  localparam logic [1:0] EV_TX = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [6:0] addr;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       i_Rst_L;
  logic       i_SPI_CS_n;
  logic       i_RX_DV;
  logic [7:0] i_RX_Byte;
  logic       o_TX_DV;
  logic [7:0] o_TX_Byte;
  logic [6:0] o_Reg_Addr;
  logic       o_Reg_WE;
  logic [7:0] o_Reg_WData;
  logic       o_Reg_RE;
  logic [7:0] i_Reg_RData = 8'h00;
  logic       o_Busy;

  ev_t        exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] bank[128];
  logic [7:0] ref_mem[128];
  logic [7:0] seed;
  logic       init_bank = 1'b0;
  logic [7:0] fb[8];

  always #5 clk = ~clk;

  spi_reg_bridge dut (
    .i_Clk       (clk),
    .i_Rst_L     (i_Rst_L),
    .i_SPI_CS_n  (i_SPI_CS_n),
    .i_RX_DV     (i_RX_DV),
    .i_RX_Byte   (i_RX_Byte),
    .o_TX_DV     (o_TX_DV),
    .o_TX_Byte   (o_TX_Byte),
    .o_Reg_Addr  (o_Reg_Addr),
    .o_Reg_WE    (o_Reg_WE),
    .o_Reg_WData (o_Reg_WData),
    .o_Reg_RE    (o_Reg_RE),
    .i_Reg_RData (i_Reg_RData),
    .o_Busy      (o_Busy)
  );

  function automatic logic [7:0] mem_init(input logic [6:0] a);
    return ({1'b0, a} * 8'd37) ^ seed;
  endfunction

  // Register bank peripheral: write on WE, read data one cycle after RE
  always @(posedge clk) begin
    if (init_bank) begin
      for (int i = 0; i < 128; i++) bank[i] <= mem_init(i[6:0]);
    end else begin
      if (o_Reg_WE) bank[o_Reg_Addr] <= o_Reg_WData;
      if (o_Reg_RE) i_Reg_RData <= bank[o_Reg_Addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_ev(input logic [1:0] kind, input logic [6:0] addr, input logic [7:0] data);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d addr %0h data %0h expected none", kind, addr, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind != EV_TX && e.addr != addr) || (kind != EV_RE && e.data != data)) begin
        n_bad++;
        $display("FAIL event: got kind %0d addr %0h data %0h expected kind %0d addr %0h data %0h",
                 kind, addr, data, e.kind, e.addr, e.data);
      end
    end
  endtask

  // Monitor: compare every DUT strobe against the head of the scoreboard
  always @(negedge clk) begin
    if (i_Rst_L === 1'b1) begin
      if (o_Reg_WE) check_ev(EV_WE, o_Reg_Addr, o_Reg_WData);
      if (o_Reg_RE) check_ev(EV_RE, o_Reg_Addr, 8'h00);
      if (o_TX_DV)  check_ev(EV_TX, 7'h00, o_TX_Byte);
    end
  end

  task automatic push(input logic [1:0] k, input logic [6:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    @(posedge clk); #1;
    i_RX_DV = 1'b1; i_RX_Byte = b;
    @(posedge clk); #1;
    i_RX_DV = 1'b0;
    repeat (GAP) @(posedge clk);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk); t++;
    end
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic cs_low();
    @(posedge clk); #1 i_SPI_CS_n = 1'b0;
    repeat (8) @(posedge clk);
    #1 chk("busy_in_frame", o_Busy, 1);
  endtask

  task automatic cs_high();
    push(EV_TX, 7'h00, STATUS);
    @(posedge clk); #1 i_SPI_CS_n = 1'b1;
    repeat (8) @(posedge clk);
    #1 chk("busy_after_frame", o_Busy, 0);
    drain("frame_drain");
  endtask

  // Reference behaviour of one frame of n bytes held in fb[]
  task automatic do_frame(input int n);
    logic       rd;
    logic [6:0] a;
    cs_low();
    rd = fb[0][7];
    a  = fb[0][6:0];
    for (int i = 0; i < n; i++) begin
      if (rd) begin
        if (i > 0) a = a + STEP;
        push(EV_RE, a, 8'h00);
        push(EV_TX, 7'h00, ref_mem[a]);
      end else if (i > 0) begin
        push(EV_WE, a, fb[i]);
        ref_mem[a] = fb[i];
        a = a + STEP;
      end
      pulse_rx(fb[i]);
    end
    cs_high();
  endtask

  task automatic frame3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int n);
    fb[0] = b0; fb[1] = b1; fb[2] = b2;
    do_frame(n);
  endtask

  // Drive the last byte so it lands in the same cycle as the synchronized CS rise
  task automatic rise_with_byte(input logic [7:0] b);
    @(posedge clk); #1 i_SPI_CS_n = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 i_RX_DV = 1'b1; i_RX_Byte = b;
    @(posedge clk); #1 i_RX_DV = 1'b0;
    repeat (8) @(posedge clk);
    #1 chk("busy_after_rise", o_Busy, 0);
    drain("rise_drain");
  endtask

  initial begin
    int n;
    seed       = 8'($urandom);
    i_Rst_L    = 1'b0;
    i_SPI_CS_n = 1'b1;
    i_RX_DV    = 1'b0;
    i_RX_Byte  = 8'h00;
    for (int i = 0; i < 128; i++) ref_mem[i] = mem_init(i[6:0]);
    init_bank = 1'b1;
    repeat (2) @(posedge clk);
    #1 init_bank = 1'b0;
    @(negedge clk);
    chk("rst_we",      o_Reg_WE, 0);
    chk("rst_re",      o_Reg_RE, 0);
    chk("rst_busy",    o_Busy, 0);
    chk("rst_addr",    o_Reg_Addr, 0);
    chk("rst_wdata",   o_Reg_WData, 0);
    chk("rst_tx_byte", o_TX_Byte, STATUS);
    push(EV_TX, 7'h00, STATUS);
    @(posedge clk); #1 i_Rst_L = 1'b1;
    repeat (4) @(posedge clk);
    drain("reset_tx");

    // Directed frames
    frame3(8'h05, 8'h11, 8'h22, 3);
    frame3(8'h10, 8'h3C, 8'h00, 2);
    frame3(8'h11, 8'h4D, 8'h00, 2);
    frame3(8'h90, 8'h00, 8'h00, 3);
    frame3(8'h07, 8'hAA, 8'hBB, 3);
    frame3(8'h7F, 8'h01, 8'h02, 3);
    frame3(8'hFF, 8'h00, 8'h00, 3);

    // Bytes outside a frame produce nothing
    pulse_rx(8'h05);
    pulse_rx(8'h33);
    drain("idle_ignore");

    // Read command coincident with frame end: no fetch, status only
    cs_low();
    push(EV_TX, 7'h00, STATUS);
    rise_with_byte(8'h90);

    // Write data coincident with frame end: write still lands, then status
    cs_low();
    pulse_rx(8'h05);
    push(EV_WE, 7'h05, 8'h77);
    ref_mem[5] = 8'h77;
    push(EV_TX, 7'h00, STATUS);
    rise_with_byte(8'h77);

    // Asynchronous reset in the middle of a write burst
    cs_low();
    push(EV_WE, 7'h20, 8'h55);
    ref_mem[32] = 8'h55;
    pulse_rx(8'h20);
    pulse_rx(8'h55);
    drain("pre_reset");
    @(posedge clk); #2 i_Rst_L = 1'b0;
    #1;
    chk("mid_rst_we",      o_Reg_WE, 0);
    chk("mid_rst_re",      o_Reg_RE, 0);
    chk("mid_rst_busy",    o_Busy, 0);
    chk("mid_rst_addr",    o_Reg_Addr, 0);
    chk("mid_rst_tx_dv",   o_TX_DV, 1);
    chk("mid_rst_tx_byte", o_TX_Byte, STATUS);
    push(EV_TX, 7'h00, STATUS);
    @(posedge clk); #1 i_Rst_L = 1'b1;
    repeat (8) @(posedge clk);
    #1 chk("busy_tracks_cs", o_Busy, 1);
    cs_high();
    frame3(8'h21, 8'h66, 8'h00, 2);
    frame3(8'hA0, 8'h00, 8'h00, 2);

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < 8; i++) fb[i] = 8'($urandom);
      if ($urandom_range(0, 3) == 0) fb[0][6:0] = ($urandom_range(0, 1) == 0) ? 7'h7F : 7'h7E;
      do_frame(n);
    end

    drain("final_drain");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
